// File: rtl/rice_core_csr_bus_arbiter.sv
// Round-robin arbiter sharing one CSR slave bus between N masters; grant held for request+response.
// Optional response watchdog enabled by defining RICE_CORE_CSR_ARB_TIMEOUT_EN.
module rice_core_csr_bus_arbiter #(
    parameter int unsigned N              = 2,
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N-1:0]               i_request_valid,
    output logic [N-1:0]               o_request_ready,
    input  logic [N*ADDR_WIDTH-1:0]    i_address,
    input  logic [N*(XLEN/8)-1:0]      i_strobe,
    input  logic [N*XLEN-1:0]          i_write_data,
    output logic [N-1:0]               o_response_valid,
    input  logic [N-1:0]               i_response_ready,
    output logic [XLEN-1:0]            o_read_data,
    output logic                       o_error,
    output logic                       o_csr_request_valid,
    input  logic                       i_csr_request_ready,
    output logic [ADDR_WIDTH-1:0]      o_csr_address,
    output logic [XLEN/8-1:0]          o_csr_strobe,
    output logic [XLEN-1:0]            o_csr_write_data,
    input  logic                       i_csr_response_valid,
    output logic                       o_csr_response_ready,
    input  logic [XLEN-1:0]            i_csr_read_data,
    input  logic                       i_csr_error,
    output logic [N-1:0]               o_grant
);

    localparam int unsigned SW = XLEN / 8;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   winner;
    logic            found;
    logic [N-1:0]    gnt_onehot;
    logic            rsp_hs;
    logic            timed_out;

    assign gnt_onehot = N'(1) << gnt_q;

    // Scan requests starting at the priority pointer, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IW'((32'(ptr_q) + i) % N);
            if (!found && i_request_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        ptr_d                = ptr_q;
        gnt_d                = gnt_q;
        rsp_hs               = 1'b0;
        o_request_ready      = '0;
        o_response_valid     = '0;
        o_read_data          = '0;
        o_error              = 1'b0;
        o_csr_request_valid  = 1'b0;
        o_csr_address        = '0;
        o_csr_strobe         = '0;
        o_csr_write_data     = '0;
        o_csr_response_ready = 1'b0;
        o_grant              = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = winner;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                o_grant                = gnt_onehot;
                o_csr_request_valid    = i_request_valid[gnt_q];
                o_csr_address          = i_address[gnt_q*ADDR_WIDTH +: ADDR_WIDTH];
                o_csr_strobe           = i_strobe[gnt_q*SW +: SW];
                o_csr_write_data       = i_write_data[gnt_q*XLEN +: XLEN];
                o_request_ready[gnt_q] = i_csr_request_ready;
                // A dropped request is a master abort: release without moving the pointer.
                if (!i_request_valid[gnt_q]) begin
                    state_d = IDLE;
                end else if (i_csr_request_ready) begin
                    state_d = RESPONSE;
                end
            end
            RESPONSE: begin
                o_grant = gnt_onehot;
                if (timed_out) begin
                    o_response_valid[gnt_q] = 1'b1;
                    o_error                 = 1'b1;
                    rsp_hs                  = i_response_ready[gnt_q];
                end else begin
                    o_response_valid[gnt_q] = i_csr_response_valid;
                    o_csr_response_ready    = i_response_ready[gnt_q];
                    o_read_data             = i_csr_read_data;
                    o_error                 = i_csr_error;
                    rsp_hs                  = i_csr_response_valid && i_response_ready[gnt_q];
                end
                if (rsp_hs) begin
                    state_d = IDLE;
                    ptr_d   = (32'(gnt_q) == N - 1) ? '0 : gnt_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef RICE_CORE_CSR_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_q;

    assign timed_out = (tmo_q == CW'(TIMEOUT_CYCLES));

    // Held at zero outside RESPONSE, so every response window starts from zero; saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else if (state_q != RESPONSE) begin
            tmo_q <= '0;
        end else if (!rsp_hs && !timed_out) begin
            tmo_q <= tmo_q + CW'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timed_out          = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_rice_core_csr_bus_arbiter.sv
// Randomized self-checking bench for rice_core_csr_bus_arbiter against a round-robin transaction model.
// Timeout scenario runs only when RICE_CORE_CSR_ARB_TIMEOUT_EN is defined.
module tb_rice_core_csr_bus_arbiter;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int AW   = 12;
    localparam int SW   = XLEN / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready, grant;
    logic [N*AW-1:0]   addr;
    logic [N*SW-1:0]   strb;
    logic [N*XLEN-1:0] wdata;
    logic [XLEN-1:0]   rdata;
    logic              err;
    logic              csr_req_valid, csr_req_ready;
    logic [AW-1:0]     csr_addr;
    logic [SW-1:0]     csr_strb;
    logic [XLEN-1:0]   csr_wdata;
    logic              csr_resp_valid, csr_resp_ready;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ptr     = 0;

    logic [AW-1:0]   m_addr  [N];
    logic [SW-1:0]   m_strb  [N];
    logic [XLEN-1:0] m_wdata [N];
    logic [N-1:0]    pend;

    always #5 clk = ~clk;

    rice_core_csr_bus_arbiter #(
        .N              (N),
        .XLEN           (XLEN),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_request_valid      (req_valid),
        .o_request_ready      (req_ready),
        .i_address            (addr),
        .i_strobe             (strb),
        .i_write_data         (wdata),
        .o_response_valid     (resp_valid),
        .i_response_ready     (resp_ready),
        .o_read_data          (rdata),
        .o_error              (err),
        .o_csr_request_valid  (csr_req_valid),
        .i_csr_request_ready  (csr_req_ready),
        .o_csr_address        (csr_addr),
        .o_csr_strobe         (csr_strb),
        .o_csr_write_data     (csr_wdata),
        .i_csr_response_valid (csr_resp_valid),
        .o_csr_response_ready (csr_resp_ready),
        .i_csr_read_data      (csr_rdata),
        .i_csr_error          (csr_err),
        .o_grant              (grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_masters();
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]     = m_addr[k];
            strb[k*SW +: SW]     = m_strb[k];
            wdata[k*XLEN +: XLEN] = m_wdata[k];
        end
        req_valid = pend;
    endtask

    task automatic new_payload(input int k);
        m_addr[k]  = AW'($urandom);
        m_strb[k]  = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
        m_wdata[k] = $urandom;
    endtask

    // Round-robin rule: first pending master at or after the pointer, wrapping.
    function automatic int model_winner(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++)
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) new_payload(k);
        pend = '1;
        drive_masters();
        csr_req_ready  = 1'b1;
        csr_resp_valid = 1'b1;
        resp_ready     = '1;
        csr_rdata      = $urandom;
        csr_err        = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({grant, req_ready, resp_valid, csr_req_valid, csr_resp_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_handshake: got %b required 0",
                     {grant, req_ready, resp_valid, csr_req_valid, csr_resp_ready});
        end
        vectors++;
        if ({csr_addr, csr_strb, csr_wdata, rdata, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_payload: got %h required 0", {csr_addr, csr_strb, csr_wdata, rdata, err});
        end
        pend = '0;
        drive_masters();
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b0;
        resp_ready     = '0;
        csr_err        = 1'b0;
        rst_n          = 1'b1;
        exp_ptr        = 0;
        tick();
    endtask

    // Runs n_txn transactions from IDLE; stall < 0 picks a random request stall per transaction.
    task automatic run_traffic(input int n_txn, input bit all_req, input int stall);
        int g, d, r, rr;
        logic [N-1:0]    gmask;
        logic [XLEN-1:0] exp_rd;
        logic            exp_err;
        for (int t = 0; t < n_txn; t++) begin
            if (all_req) pend = '1;
            else begin
                for (int k = 0; k < N; k++)
                    if (!pend[k] && $urandom_range(0, 1) == 1) begin
                        pend[k] = 1'b1;
                        new_payload(k);
                    end
                if (pend == '0) begin
                    g = $urandom_range(0, N - 1);
                    pend[g] = 1'b1;
                    new_payload(g);
                end
            end
            drive_masters();
            csr_req_ready  = 1'b0;
            csr_resp_valid = 1'b0;
            resp_ready     = '0;
            #1;
            vectors++;
            if ({grant, csr_req_valid} !== '0) begin
                miscompares++;
                $display("FAIL idle_arb: grant/csr_valid got %b required 0", {grant, csr_req_valid});
            end
            g     = model_winner(pend, exp_ptr);
            gmask = N'(1) << g;
            tick();
            d = (stall >= 0) ? stall : $urandom_range(0, 3);
            for (int c = 0; c <= d; c++) begin
                csr_req_ready = (c == d);
                #1;
                vectors++;
                if (grant !== gmask) begin
                    miscompares++;
                    $display("FAIL req_grant: txn %0d got %b required %b", t, grant, gmask);
                end
                vectors++;
                if ({csr_req_valid, csr_addr, csr_strb, csr_wdata} !== {1'b1, m_addr[g], m_strb[g], m_wdata[g]}) begin
                    miscompares++;
                    $display("FAIL req_payload: txn %0d got %h required %h", t,
                             {csr_req_valid, csr_addr, csr_strb, csr_wdata},
                             {1'b1, m_addr[g], m_strb[g], m_wdata[g]});
                end
                vectors++;
                if (req_ready !== ((c == d) ? gmask : '0)) begin
                    miscompares++;
                    $display("FAIL req_ready: txn %0d cycle %0d got %b required %b", t, c, req_ready,
                             (c == d) ? gmask : '0);
                end
                tick();
            end
            if (all_req) new_payload(g);
            else begin
                pend[g] = ($urandom_range(0, 1) == 1);
                if (pend[g]) new_payload(g);
            end
            drive_masters();
            csr_req_ready = 1'b0;
            r       = $urandom_range(0, 2);
            rr      = $urandom_range(0, 1);
            exp_rd  = $urandom;
            exp_err = 1'($urandom_range(0, 1));
            csr_rdata = exp_rd;
            csr_err   = exp_err;
            for (int c = 0; c <= r + rr; c++) begin
                csr_resp_valid = (c >= r);
                resp_ready     = (N'($urandom) & ~gmask) | ((c == r + rr) ? gmask : '0);
                #1;
                vectors++;
                if (grant !== gmask) begin
                    miscompares++;
                    $display("FAIL rsp_grant: txn %0d got %b required %b", t, grant, gmask);
                end
                vectors++;
                if (resp_valid !== ((c >= r) ? gmask : '0)) begin
                    miscompares++;
                    $display("FAIL rsp_valid: txn %0d cycle %0d got %b required %b", t, c, resp_valid,
                             (c >= r) ? gmask : '0);
                end
                vectors++;
                if (csr_resp_ready !== (c == r + rr)) begin
                    miscompares++;
                    $display("FAIL rsp_ready: txn %0d cycle %0d got %b required %b", t, c, csr_resp_ready,
                             (c == r + rr));
                end
                vectors++;
                if ({csr_req_valid, csr_addr} !== '0) begin
                    miscompares++;
                    $display("FAIL rsp_payload_zero: txn %0d got %h required 0", t, {csr_req_valid, csr_addr});
                end
                if (c >= r) begin
                    vectors++;
                    if ({rdata, err} !== {exp_rd, exp_err}) begin
                        miscompares++;
                        $display("FAIL rsp_data: txn %0d got %h/%b required %h/%b", t, rdata, err, exp_rd, exp_err);
                    end
                end
                tick();
            end
            csr_resp_valid = 1'b0;
            resp_ready     = '0;
            exp_ptr        = (g + 1) % N;
        end
    endtask

    task automatic test_contention();
        new_payload(0);
        m_addr[1]  = 12'h341;
        m_wdata[1] = 32'h8000_0004;
        m_strb[1]  = 4'hF;
        run_traffic(4, 1'b1, -1);
    endtask

    task automatic test_single();
        pend       = 2'b01;
        m_addr[0]  = 12'h300;
        m_strb[0]  = '0;
        m_wdata[0] = $urandom;
        drive_masters();
        csr_req_ready = 1'b1;
        resp_ready    = 2'b01;
        #1;
        vectors++;
        if ({grant, csr_req_valid} !== '0) begin
            miscompares++;
            $display("FAIL single_idle: got %b required 0", {grant, csr_req_valid});
        end
        tick();
        vectors++;
        if ({grant, req_ready, csr_req_valid, csr_addr, csr_strb} !== {2'b01, 2'b01, 1'b1, 12'h300, 4'h0}) begin
            miscompares++;
            $display("FAIL single_req: got %h required %h", {grant, req_ready, csr_req_valid, csr_addr, csr_strb},
                     {2'b01, 2'b01, 1'b1, 12'h300, 4'h0});
        end
        tick();
        pend = '0;
        drive_masters();
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b1;
        csr_rdata      = 32'h0000_1800;
        csr_err        = 1'b0;
        #1;
        vectors++;
        if ({grant, resp_valid, rdata, err, csr_resp_ready} !== {2'b01, 2'b01, 32'h0000_1800, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_rsp: got %h required %h", {grant, resp_valid, rdata, err, csr_resp_ready},
                     {2'b01, 2'b01, 32'h0000_1800, 1'b0, 1'b1});
        end
        tick();
        csr_resp_valid = 1'b0;
        resp_ready     = '0;
        #1;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL single_release: grant got %b required 00", grant);
        end
        exp_ptr = 1;
    endtask

    task automatic test_error();
        pend      = 2'b01;
        m_addr[0] = 12'hFFF;
        m_strb[0] = '0;
        drive_masters();
        csr_req_ready = 1'b1;
        resp_ready    = 2'b11;
        tick();
        tick();
        pend = '0;
        drive_masters();
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b1;
        csr_rdata      = $urandom;
        csr_err        = 1'b1;
        #1;
        vectors++;
        if ({resp_valid, err} !== {2'b01, 1'b1}) begin
            miscompares++;
            $display("FAIL error_rsp: valid/err got %b/%b required 01/1", resp_valid, err);
        end
        tick();
        csr_resp_valid = 1'b0;
        csr_err        = 1'b0;
        resp_ready     = '0;
        exp_ptr        = 1;
        pend = 2'b11;
        drive_masters();
        tick();
        vectors++;
        if (grant !== 2'b10) begin
            miscompares++;
            $display("FAIL error_ptr: grant got %b required 10", grant);
        end
        pend = '0;
        drive_masters();
        tick();
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_release: grant got %b required 00", grant);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < N; k++) new_payload(k);
        run_traffic(1, 1'b1, 5);
    endtask

    task automatic test_random_traffic();
        pend = '0;
        run_traffic(40, 1'b0, -1);
        pend = '0;
        drive_masters();
    endtask

    task automatic test_reset_mid_response();
        pend = 2'b10;
        new_payload(1);
        drive_masters();
        csr_req_ready = 1'b1;
        resp_ready    = '0;
        tick();
        tick();
        pend = '0;
        drive_masters();
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b1;
        #1;
        vectors++;
        if ({grant, resp_valid} !== {2'b10, 2'b10}) begin
            miscompares++;
            $display("FAIL mid_rsp_setup: got %b required 1010", {grant, resp_valid});
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({grant, req_ready, resp_valid, csr_req_valid, csr_resp_ready} !== '0) begin
            miscompares++;
            $display("FAIL mid_rsp_reset: got %b required 0",
                     {grant, req_ready, resp_valid, csr_req_valid, csr_resp_ready});
        end
        tick();
        csr_resp_valid = 1'b0;
        pend = 2'b11;
        drive_masters();
        rst_n = 1'b1;
        exp_ptr = 0;
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL post_reset_winner: grant got %b required 01", grant);
        end
        pend = '0;
        drive_masters();
        tick();
        pend = 2'b11;
        drive_masters();
        tick();
        vectors++;
        if (grant !== 2'b01) begin
            miscompares++;
            $display("FAIL abort_ptr_hold: grant got %b required 01", grant);
        end
        pend = '0;
        drive_masters();
        tick();
    endtask

`ifdef RICE_CORE_CSR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pend = 2'b01;
        new_payload(0);
        drive_masters();
        csr_req_ready = 1'b1;
        tick();
        tick();
        pend = '0;
        drive_masters();
        csr_req_ready  = 1'b0;
        csr_resp_valid = 1'b0;
        csr_rdata      = 32'hDEAD_BEEF;
        csr_err        = 1'b0;
        resp_ready     = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (resp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL timeout_early: cycle %0d resp_valid got %b required 00", c, resp_valid);
            end
            tick();
        end
        #1;
        vectors++;
        if ({resp_valid, err, rdata, csr_resp_ready} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: got %h required %h", {resp_valid, err, rdata, csr_resp_ready},
                     {2'b01, 1'b1, 32'h0, 1'b0});
        end
        tick();
        resp_ready = '0;
        vectors++;
        if (grant !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_release: grant got %b required 00", grant);
        end
        exp_ptr = 1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_error();
        test_stall();
        test_random_traffic();
        test_reset_mid_response();
`ifdef RICE_CORE_CSR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rice_core_csr_bus_arbiter.md
Name: rice_core_csr_bus_arbiter

Overview:
- Shares one CSR slave bus between N CSR masters, e.g. the core CSR read/write unit and the debug module.
- Round-robin arbitration. Grant is locked for one full transaction: request handshake followed by response handshake.
- Sits between the masters and the CSR register file.
- Each side uses the valid/ready request and response handshake of the core bus.

Parameters:
- N: default 2. Number of masters; legal range 2..8.
- XLEN: default 32. Data width.
- ADDR_WIDTH: default 12. CSR address width.
- TIMEOUT_CYCLES: default 255. Response watchdog limit. Used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_request_valid  in  N  per-master request valid.
- o_request_ready  out  N  per-master request ready.
- i_address  in  N*ADDR_WIDTH  per-master address. Master k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_strobe  in  N*(XLEN/8)  per-master byte strobe. All zero = read.
- i_write_data  in  N*XLEN  per-master write data.
- o_response_valid  out  N  per-master response valid.
- i_response_ready  in  N  per-master response ready.
- o_read_data  out  XLEN  read data, broadcast to all masters.
- o_error  out  1  error, broadcast to all masters.
- o_csr_request_valid  out  1  slave request valid.
- i_csr_request_ready  in  1  slave request ready.
- o_csr_address  out  ADDR_WIDTH  slave address.
- o_csr_strobe  out  XLEN/8  slave strobe.
- o_csr_write_data  out  XLEN  slave write data.
- i_csr_response_valid  in  1  slave response valid.
- o_csr_response_ready  out  1  slave response ready.
- i_csr_read_data  in  XLEN  slave read data.
- i_csr_error  in  1  slave error.
- o_grant  out  N  one-hot grant, 0 when idle.

Behaviour:
- Reset values:
  - state = IDLE, priority pointer = 0, grant index = 0.
  - o_grant = 0; all valid/ready outputs = 0.
  - Slave payload outputs = 0 whenever state != REQUEST.
- IDLE:
  - Search i_request_valid starting at the priority pointer, wrapping modulo N; the first set bit wins.
  - The winner index is registered; next state is REQUEST.
  - Arbitration costs exactly 1 cycle. No slave signal is driven in IDLE.
  - No request pending: stay in IDLE.
- REQUEST:
  - o_csr_request_valid = i_request_valid[g].
  - Payload is muxed from master g.
  - o_request_ready[g] = i_csr_request_ready; all other ready bits = 0.
  - Handshake (valid && ready): next state is RESPONSE.
  - If i_request_valid[g] drops before the handshake (master abort): return to IDLE with the pointer unchanged.
- RESPONSE:
  - o_response_valid[g] = i_csr_response_valid; all others = 0.
  - o_csr_response_ready = i_response_ready[g].
  - o_read_data and o_error pass through combinationally.
  - Response handshake: next state is IDLE and pointer = (g+1) mod N.
- o_grant is one-hot of g in REQUEST/RESPONSE and 0 in IDLE.
- Only one transaction is outstanding at any time. Requests from non-granted masters see ready = 0 and must be held.
- Back-to-back throughput: 1 idle arbitration cycle between transactions.
- Simultaneous requests from all N masters: each master is served exactly once per N transactions.
- Request ack and response valid in the same cycle: the response is not consumed until the RESPONSE state (one-cycle pipeline). The slave must tolerate this.
- Asynchronous reset mid-transaction:
  - Aborts immediately: all outputs go to reset values, pointer = 0.
  - Slave-side in-flight state is the slave's responsibility.

Optional Feature:
- Macro: RICE_CORE_CSR_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to RESPONSE and increments each RESPONSE cycle without a response handshake.
  - When count == TIMEOUT_CYCLES, the arbiter substitutes a response to master g: o_response_valid[g] = 1, o_error = 1, o_read_data = 0, o_csr_response_ready = 0.
  - The substitute response completes like a normal one: on i_response_ready[g], next state is IDLE and the pointer advances.
  - A slave must not respond after a timeout.
  - The counter width is sized by $clog2(TIMEOUT_CYCLES+1).
- When undefined: no counter exists, and RESPONSE waits indefinitely.

Test Plan:
- Single master: master0 reads 0x300; slave returns 0x00001800 one cycle after request ack.
  - Expect o_grant=01 for 2 cycles, o_response_valid=01, o_read_data=0x00001800, o_error=0.
- Contention: both masters request continuously; master1 writes 0x341 with data 0x80000004, strobe F.
  - Expect grant order 0,1,0,1 and each slave write to carry the correct master's payload.
- Stall: slave holds i_csr_request_ready=0 for 5 cycles.
  - Expect payload stable, o_request_ready[0]=0, no other master granted.
- Error: slave returns i_csr_error=1 for address 0xFFF.
  - Expect o_error=1 to master0 only, then pointer = 1.
- Reset mid-RESPONSE: assert i_rst_n=0 while granted to master1.
  - Expect immediate o_grant=0, all valids 0; after release, master1 and master0 both request → master0 wins.
- With RICE_CORE_CSR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave never responds.
  - Expect o_response_valid[g]=1, o_error=1, o_read_data=0 after 4 RESPONSE cycles, then return to IDLE.
